// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  // STATUS register bit positions
  localparam int unsigned ST_BUSY    = 0;
  localparam int unsigned ST_FULL    = 1;
  localparam int unsigned ST_OVF     = 2;
  localparam int unsigned ST_EMPTY   = 3;
  localparam int unsigned ST_CNT_LSB = 8;

  // Register offsets from the base address
  localparam logic [31:0] OFS_TXDATA = 32'h0000_0000;
  localparam logic [31:0] OFS_STATUS = 32'h0000_0004;

  // Word-address compare; the byte offset bits [1:0] are ignored.
  function automatic logic word_match(input logic [31:0] a, input logic [31:0] b);
    return ((a ^ b) & 32'hFFFF_FFFC) == 32'h0;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous circular FIFO with simultaneous push/pop and fall-through read data.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_pop;
  logic w_do_push;

  assign w_do_pop  = pop & ~empty;
  // A push into a full FIFO is only legal when a pop frees the slot in the same cycle.
  assign w_do_push = push & (~full | w_do_pop);

  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign dout  = r_mem[r_rd_ptr];

  // Storage write; contents need no reset since count gates validity.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_do_push && w_do_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS decode, TX FIFO and serializer FSM.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic        bus_we,
  input  logic        bus_re,
  output logic [31:0] bus_rdata,
  output logic        bus_hit,
  output logic        tx,
  output logic        tx_busy
);

  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  // Address decode
  logic w_hit_tx;
  logic w_hit_st;
  logic w_wr_tx;
  logic w_wr_st;

  assign w_hit_tx = word_match(bus_addr, BASE_ADDR + OFS_TXDATA);
  assign w_hit_st = word_match(bus_addr, BASE_ADDR + OFS_STATUS);
  assign bus_hit  = w_hit_tx | w_hit_st;
  assign w_wr_tx  = bus_we & w_hit_tx;
  assign w_wr_st  = bus_we & w_hit_st;

  // Reads are side-effect free and the upper TXDATA bits are don't-care.
  logic w_unused;
  assign w_unused = bus_re ^ (^bus_wdata[31:8]);

  // FIFO interface
  logic             w_fifo_push;
  logic             w_fifo_pop;
  logic [7:0]       w_fifo_dout;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [CNT_W-1:0] w_fifo_count;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_ovf_set;

  assign w_fifo_push = w_wr_tx & (~w_fifo_full | w_fifo_pop);
  assign w_ovf_set   = w_wr_tx & w_fifo_full & ~w_fifo_pop;
  assign w_cnt_next  = w_fifo_count + CNT_W'(w_fifo_push) - CNT_W'(w_fifo_pop);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_fifo_push),
    .pop   (w_fifo_pop),
    .din   (bus_wdata[7:0]),
    .dout  (w_fifo_dout),
    .full  (w_fifo_full),
    .empty (w_fifo_empty),
    .count (w_fifo_count)
  );

  // Sticky overflow flag; a new overflow beats a same-cycle software clear.
  logic r_ovf;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_set) begin
      r_ovf <= 1'b1;
    end else if (w_wr_st && bus_wdata[ST_OVF]) begin
      r_ovf <= 1'b0;
    end
  end

  // Serializer state
  uart_state_e       r_state;
  uart_state_e       w_state_d;
  logic [BAUD_W-1:0] r_baud;
  logic [BAUD_W-1:0] w_baud_d;
  logic [2:0]        r_bit_idx;
  logic [2:0]        w_bit_idx_d;
  logic [7:0]        r_shift;
  logic [7:0]        w_shift_d;
  logic              r_tx;
  logic              w_tx_d;
  logic              r_busy;
  logic              w_busy_d;
  logic              w_baud_last;

  assign w_baud_last = (r_baud == BAUD_LAST);

  // Busy looks at the post-edge state so it is registered yet coincident with the edge.
  assign w_busy_d = (w_state_d != IDLE) || (w_cnt_next != '0);

  // State, counters and line outputs registered together so tx is glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_baud    <= w_baud_d;
      r_bit_idx <= w_bit_idx_d;
      r_shift   <= w_shift_d;
      r_tx      <= w_tx_d;
      r_busy    <= w_busy_d;
    end
  end

  // Next-state logic; tx_d is the line level for the cycle after this edge.
  always_comb begin
    w_state_d   = r_state;
    w_baud_d    = r_baud + 1'b1;
    w_bit_idx_d = r_bit_idx;
    w_shift_d   = r_shift;
    w_tx_d      = r_tx;
    w_fifo_pop  = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_baud_d = '0;
        w_tx_d   = 1'b1;
        if (!w_fifo_empty) begin
          w_fifo_pop = 1'b1;
          w_shift_d  = w_fifo_dout;
          w_state_d  = START;
          w_tx_d     = 1'b0;
        end
      end
      START: begin
        w_tx_d = 1'b0;
        if (w_baud_last) begin
          w_state_d   = DATA;
          w_baud_d    = '0;
          w_bit_idx_d = '0;
          w_tx_d      = r_shift[0];
        end
      end
      DATA: begin
        w_tx_d = r_shift[0];
        if (w_baud_last) begin
          w_baud_d = '0;
          if (r_bit_idx == 3'd7) begin
            w_state_d = STOP;
            w_tx_d    = 1'b1;
          end else begin
            w_shift_d   = {1'b0, r_shift[7:1]};
            w_bit_idx_d = r_bit_idx + 1'b1;
            w_tx_d      = r_shift[1];
          end
        end
      end
      STOP: begin
        w_tx_d = 1'b1;
        if (w_baud_last) begin
          w_baud_d = '0;
          if (!w_fifo_empty) begin
            // Back-to-back frame: no idle bit between stop and next start.
            w_fifo_pop = 1'b1;
            w_shift_d  = w_fifo_dout;
            w_state_d  = START;
            w_tx_d     = 1'b0;
          end else begin
            w_state_d = IDLE;
          end
        end
      end
      default: begin
        w_state_d = IDLE;
        w_baud_d  = '0;
        w_tx_d    = 1'b1;
      end
    endcase
  end

  assign tx      = r_tx;
  assign tx_busy = r_busy;

  // STATUS word assembly and read mux.
  logic [31:0] w_status;
  always_comb begin
    w_status                   = '0;
    w_status[ST_BUSY]          = r_busy;
    w_status[ST_FULL]          = w_fifo_full;
    w_status[ST_OVF]           = r_ovf;
    w_status[ST_EMPTY]         = w_fifo_empty;
    w_status[ST_CNT_LSB +: 8]  = 8'(w_fifo_count);
  end

  assign bus_rdata = w_hit_st ? w_status : 32'h0;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench: randomized and directed MMIO traffic against a frame-timeline model.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int C = 16;
  localparam int D = 8;
  localparam int FRAME = 10 * C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] bus_addr = '0;
  logic [31:0] bus_wdata = '0;
  logic        bus_we = 1'b0;
  logic        bus_re = 1'b0;
  logic [31:0] bus_rdata;
  logic        bus_hit;
  logic        tx;
  logic        tx_busy;

  mmio_uart_tx #(
    .BASE_ADDR    (BASE),
    .FIFO_DEPTH   (D),
    .CLKS_PER_BIT (C)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_we    (bus_we),
    .bus_re    (bus_re),
    .bus_rdata (bus_rdata),
    .bus_hit   (bus_hit),
    .tx        (tx),
    .tx_busy   (tx_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: queued bytes plus the frame on the wire and its age in cycles.
  logic [7:0] m_q[$];
  logic [7:0] m_cur = '0;
  bit         m_active = 1'b0;
  int         m_elapsed = 0;
  bit         m_ovf = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit same_word(input logic [31:0] a, input logic [31:0] b);
    return (a >> 2) == (b >> 2);
  endfunction

  function automatic logic exp_tx();
    int seg;
    if (!m_active) return 1'b1;
    seg = m_elapsed / C;
    if (seg == 0) return 1'b0;
    if (seg == 9) return 1'b1;
    return m_cur[seg-1];
  endfunction

  function automatic logic exp_busy();
    return m_active || (m_q.size() > 0);
  endfunction

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = 32'(m_q.size()) << 8;
    s[0] = exp_busy();
    s[1] = (m_q.size() == D);
    s[2] = m_ovf;
    s[3] = (m_q.size() == 0);
    return s;
  endfunction

  // Advance the model across one clock edge with the given bus inputs.
  task automatic model_edge(input bit r, input bit we, input logic [31:0] a,
                            input logic [31:0] wd);
    bit ovf_set;
    if (r) begin
      m_q.delete();
      m_active = 1'b0;
      m_elapsed = 0;
      m_ovf = 1'b0;
      return;
    end
    ovf_set = 1'b0;
    if (m_active) begin
      m_elapsed++;
      if (m_elapsed == FRAME) m_active = 1'b0;
    end
    if (!m_active && m_q.size() > 0) begin
      m_cur = m_q.pop_front();
      m_active = 1'b1;
      m_elapsed = 0;
    end
    if (we && same_word(a, BASE)) begin
      if (m_q.size() < D) m_q.push_back(wd[7:0]);
      else ovf_set = 1'b1;
    end
    if (we && same_word(a, BASE + 4) && wd[2]) m_ovf = 1'b0;
    if (ovf_set) m_ovf = 1'b1;
  endtask

  // One clock: drive, edge, update model, check line/busy, then read STATUS.
  task automatic step(input bit r, input bit we, input logic [31:0] a, input logic [31:0] wd);
    rst = r;
    bus_we = we;
    bus_addr = a;
    bus_wdata = wd;
    bus_re = 1'b0;
    @(posedge clk);
    model_edge(r, we, a, wd);
    #1;
    check_eq("tx", 32'(tx), 32'(exp_tx()));
    check_eq("tx_busy", 32'(tx_busy), 32'(exp_busy()));
    rst = 1'b0;
    bus_we = 1'b0;
    bus_re = 1'b1;
    bus_addr = BASE + 4;
    #1;
    check_eq("status", bus_rdata, exp_status());
    check_eq("status_hit", 32'(bus_hit), 32'd1);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic wr(input logic [31:0] wd);
    step(1'b0, 1'b1, BASE, wd);
  endtask

  task automatic probe(input logic [31:0] a);
    bit hit_st;
    bus_addr = a;
    bus_re = 1'b1;
    #1;
    hit_st = same_word(a, BASE + 4);
    check_eq("probe_hit", 32'(bus_hit), 32'(same_word(a, BASE) || hit_st));
    check_eq("probe_rdata", bus_rdata, hit_st ? exp_status() : 32'h0);
  endtask

  // Idle until tx_busy drops; returns the number of cycles spent.
  task automatic drain(input int bound, output int n);
    n = 0;
    while (tx_busy && n < bound) begin
      idle();
      n++;
    end
    check_eq("drain_bound", 32'(n < bound), 32'd1);
  endtask

  task automatic wait_age(input int age, input int bound);
    int n;
    n = 0;
    while (!(m_active && m_elapsed == age) && n < bound) begin
      idle();
      n++;
    end
    check_eq("wait_bound", 32'(n < bound), 32'd1);
  endtask

  initial begin
    int n;
    int r;

    // Reset
    repeat (3) step(1'b1, 1'b0, 32'h0, 32'h0);
    check_eq("rst_tx", 32'(tx), 32'd1);
    check_eq("rst_busy", 32'(tx_busy), 32'd0);
    check_eq("rst_status", bus_rdata, 32'h0000_0008);
    probe(BASE);
    check_eq("txdata_read", bus_rdata, 32'h0);

    // Single byte: busy falls 160 cycles after the start edge
    wr(32'hFFFF_FF55);
    drain(400, n);
    check_eq("single_len", 32'(n), 32'(FRAME + 1));

    // Burst of three contiguous frames
    wr(32'h41);
    wr(32'h42);
    wr(32'h43);
    check_eq("burst_cnt", 32'(bus_rdata[15:8]), 32'd2);
    drain(1000, n);
    check_eq("burst_len", 32'(n), 32'(3 * FRAME - 1));

    // Overflow: 10 writes, 1 popped, 8 queued, 1 dropped
    for (int i = 0; i < 10; i++) wr(32'($urandom_range(0, 255)));
    check_eq("ovf_status", bus_rdata, 32'h0000_0807);
    step(1'b0, 1'b1, BASE + 4, 32'h4);
    check_eq("ovf_clear", bus_rdata, 32'h0000_0803);
    drain(2000, n);

    // Full FIFO with a push on the exact STOP->START pop edge
    for (int i = 0; i < 9; i++) wr(32'($urandom_range(0, 255)));
    check_eq("full_cnt", 32'(bus_rdata[15:8]), 32'd8);
    wait_age(FRAME - 1, 400);
    wr(32'hA5);
    check_eq("fullpop_cnt", 32'(bus_rdata[15:8]), 32'd8);
    check_eq("fullpop_ovf", 32'(bus_rdata[2]), 32'd0);
    drain(2000, n);

    // Reset during data bit 3
    wr(32'h3C);
    wr(32'h81);
    wr(32'h7E);
    wait_age(4 * C + 5, 400);
    step(1'b1, 1'b0, 32'h0, 32'h0);
    check_eq("mid_rst_tx", 32'(tx), 32'd1);
    check_eq("mid_rst_cnt", 32'(bus_rdata[15:8]), 32'd0);
    wr(32'h96);
    drain(400, n);
    check_eq("post_rst_len", 32'(n), 32'(FRAME + 1));

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 6) begin
        wr($urandom());
      end else if (r < 7) begin
        step(1'b0, 1'b1, BASE + 32'($urandom_range(1, 3)), $urandom());
      end else if (r < 9) begin
        step(1'b0, 1'b1, BASE + 4 + 32'($urandom_range(0, 3)), $urandom());
      end else if (r < 11) begin
        step(1'b0, 1'b1, $urandom(), $urandom());
      end else begin
        idle();
      end
      if (r >= 90) probe($urandom());
      else if (r >= 85) probe(BASE + 32'($urandom_range(0, 7)));
    end
    drain(3000, n);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter that consumes the store stream CPUTop issues to its I/O window. CPU writes to TXDATA are queued in a small FIFO and serialized 8N1 on a single output pin. The CPU polls STATUS for busy, full and overflow. It is the first consumer of CPU output and replaces the bench's direct watch of mem[0x1000].

Parameters:
BASE_ADDR, 32'h0000_1000, address of TXDATA; STATUS is at BASE_ADDR+4
FIFO_DEPTH, 8, TX FIFO entries; must be a power of two, at least 2
CLKS_PER_BIT, 16, clk cycles per serial bit; must be at least 2

Ports:
clk  in  1  system clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
bus_addr  in  32  CPU data-bus byte address
bus_wdata  in  32  CPU store data
bus_we  in  1  store strobe, one cycle per store
bus_re  in  1  load strobe
bus_rdata  out  32  read data, combinational from bus_addr
bus_hit  out  1  high when bus_addr is TXDATA or STATUS
tx  out  1  serial line, idle high
tx_busy  out  1  FSM not IDLE, or FIFO non-empty

Behaviour:
- Reset is synchronous: on a posedge with rst=1, all state clears.
  - tx=1, tx_busy=0, FIFO empty (count=0, pointers=0), overflow=0, FSM=IDLE, bit and baud counters=0.
  - bus_rdata=0 unless a STATUS read is decoded.
  - Reset mid-frame aborts the frame: tx=1 on the next cycle and queued bytes are discarded.
- Address decode is exact-match on the word address; bus_addr[1:0] is ignored. Other addresses give bus_hit=0 and bus_rdata=0.
- TXDATA write (bus_we, addr==BASE_ADDR): bus_wdata[7:0] is pushed at that posedge; upper bits are ignored.
  - If the FIFO is full and no pop occurs in that cycle, the byte is dropped and overflow is set (sticky).
  - If full and a pop occurs in the same cycle, the push is accepted and count is unchanged.
- STATUS read: bit0=tx_busy, bit1=fifo_full, bit2=overflow, bit3=fifo_empty, [15:8]=count (zero-extended), all other bits 0.
  - TXDATA reads return 0.
  - Reads have no side effects.
- STATUS write: wdata[2]=1 clears overflow. If an overflow event occurs in the same cycle, set wins.
- FIFO: circular buffer, pointers wrap modulo FIFO_DEPTH, count ranges 0..FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If the FIFO is non-empty at a posedge, pop the head into shift_reg, go to START, baud counter=0. tx falls to 0 at that same edge.
  - Latency: a write at edge k gives tx=0 after edge k+1 when the FSM is idle.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift_reg[0], LSB first; shift after each CLKS_PER_BIT cycles; after bit index 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then, if the FIFO is non-empty, pop and go directly to START (back-to-back, no idle gap); otherwise go to IDLE.
  - One frame occupies exactly 10*CLKS_PER_BIT cycles.
- tx and tx_busy are registered outputs, glitch-free.

Decomposition:
- Shared package uart_pkg:
  - state enum {IDLE, START, DATA, STOP}
  - STATUS bit-index constants (ST_BUSY=0, ST_FULL=1, ST_OVF=2, ST_EMPTY=3, ST_CNT_LSB=8)
  - address offsets (OFS_TXDATA=0, OFS_STATUS=4)
- One sub-module, sync_fifo: parameterized width and depth. Ports: push, pop, din, dout, full, empty, count. Same clk/rst, synchronous reset, supports simultaneous push and pop.
- The top module holds the decode, status register, and serializer FSM.

Test Plan:
- Reset: hold rst 3 cycles -> tx=1, tx_busy=0, STATUS read=32'h0000_0008.
- Single byte: write 32'hFFFF_FF55 to 0x1000 at edge k -> tx=0 from edge k+1 for 16 cycles. Then bits 1,0,1,0,1,0,1,0 at 16 cycles each, stop=1. tx_busy falls 160 cycles after k+1.
- Burst with CLKS_PER_BIT=16: write 0x41, 0x42, 0x43 on consecutive cycles -> three contiguous frames with no gap (480 cycles). STATUS count reads 2 right after the first pop.
- Overflow with FIFO_DEPTH=8: while frame 0 is sending, write 10 bytes -> 1 popped, 8 queued, 1 dropped. STATUS=32'h0000_0807 (count 8, ovf, full, busy). Write 32'h4 to 0x1004 -> bit2 clears.
- Full plus pop: fill the FIFO, then write in the exact cycle of the STOP->START pop -> byte accepted, count stays 8, overflow stays 0.
- Mid-frame reset: assert rst during DATA bit 3 -> next cycle tx=1, count=0. Later writes transmit normally.
